// File: rtl/mem_seq_control_if.sv
// LC-3b opcode encoding and the MEM-stage sequencer bus (pipeline side and memory side).
// The master modport drives the instruction and memory response; the slave is the sequencer.
package lc3b_pkg;
    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;
endpackage

interface mem_seq_control_if #(
    parameter int DATA_WIDTH = 16
);
    import lc3b_pkg::*;

    logic                  stage_valid;
    lc3b_opcode            opcode;
    logic                  mem_resp;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  proceed;
    logic                  mem_read;
    logic                  mem_write;
    logic                  addr_sel;
    logic                  ptr_load;
    logic [DATA_WIDTH-1:0] ptr_reg;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        output stage_valid, opcode, mem_resp, mem_rdata,
        input  proceed, mem_read, mem_write, addr_sel, ptr_load, ptr_reg, busy, timeout_err
    );

    modport slave (
        input  stage_valid, opcode, mem_resp, mem_rdata,
        output proceed, mem_read, mem_write, addr_sel, ptr_load, ptr_reg, busy, timeout_err
    );
endinterface

// File: rtl/mem_seq_control.sv
// MEM-stage access sequencer: direct accesses in one step, indirect ones as a pointer chain.
// Define MEM_SEQ_TIMEOUT_EN to build the per-access wait limit and timeout_err abort.
module mem_seq_control
    import lc3b_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int INDIRECT_DEPTH = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_seq_control_if.slave   bus
);
    localparam int CNT_W = $clog2(INDIRECT_DEPTH + 1);
    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(INDIRECT_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PTR, S_FINAL} state_t;

    state_t                r_state;
    logic                  r_store;
    logic [CNT_W-1:0]      r_ptr_cnt;
    logic [DATA_WIDTH-1:0] r_ptr_reg;

    logic             w_is_load, w_is_store, w_is_ind;
    logic             w_rd, w_wr, w_sel, w_proceed, w_ptr_load, w_timeout;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_is_load  = bus.opcode inside {op_ldr, op_ldb, op_trap};
    assign w_is_store = bus.opcode inside {op_str, op_stb};
    assign w_is_ind   = bus.opcode inside {op_ldi, op_sti};
    assign w_cnt_inc  = r_ptr_cnt + CNT_W'(1);

    always_comb begin
        w_rd      = 1'b0;
        w_wr      = 1'b0;
        w_sel     = 1'b0;
        w_proceed = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.stage_valid) begin
                    w_proceed = 1'b1;
                end else if (w_is_load) begin
                    w_rd      = 1'b1;
                    w_proceed = bus.mem_resp;
                end else if (w_is_store) begin
                    w_wr      = 1'b1;
                    w_proceed = bus.mem_resp;
                end else if (w_is_ind) begin
                    w_rd = 1'b1;
                end else begin
                    w_proceed = 1'b1;
                end
            end
            S_PTR: begin
                w_sel = 1'b1;
                w_rd  = 1'b1;
            end
            S_FINAL: begin
                w_sel     = 1'b1;
                w_wr      = r_store;
                w_rd      = !r_store;
                w_proceed = bus.mem_resp;
            end
            default: ;
        endcase
    end

    assign w_ptr_load = bus.mem_resp &&
                        (((r_state == S_IDLE) && bus.stage_valid && w_is_ind) || (r_state == S_PTR));

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_wait;
    logic            w_strobe;

    assign w_strobe  = w_rd || w_wr;
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle of waiting.
    assign w_timeout = w_strobe && !bus.mem_resp && (r_wait == TO_W'(TIMEOUT_CYCLES - 1));

    // State only moves on mem_resp or timeout, so those cover the state-change clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (!w_strobe || bus.mem_resp || w_timeout) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + TO_W'(1);
        end
    end
`else
    logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] w_unused_to;
    assign w_unused_to = '0;
    assign w_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_store   <= 1'b0;
            r_ptr_cnt <= '0;
            r_ptr_reg <= '0;
        end else begin
            if (w_ptr_load) begin
                r_ptr_reg <= bus.mem_rdata;
            end
            if (w_timeout) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.stage_valid && w_is_ind && bus.mem_resp) begin
                            r_store   <= (bus.opcode == op_sti);
                            r_ptr_cnt <= CNT_W'(1);
                            r_state   <= (INDIRECT_DEPTH > 1) ? S_PTR : S_FINAL;
                        end
                    end
                    S_PTR: begin
                        if (bus.mem_resp) begin
                            r_ptr_cnt <= w_cnt_inc;
                            if (w_cnt_inc == LP_DEPTH) begin
                                r_state <= S_FINAL;
                            end
                        end
                    end
                    S_FINAL: begin
                        if (bus.mem_resp) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Reset gates every combinational output so an in-flight chain aborts with no pulse.
    assign bus.proceed     = !reset && (w_proceed || w_timeout);
    assign bus.mem_read    = !reset && w_rd && !w_timeout;
    assign bus.mem_write   = !reset && w_wr && !w_timeout;
    assign bus.addr_sel    = !reset && w_sel;
    assign bus.ptr_load    = !reset && w_ptr_load;
    assign bus.busy        = !reset && (r_state != S_IDLE);
    assign bus.timeout_err = !reset && w_timeout;
    assign bus.ptr_reg     = r_ptr_reg;
endmodule

// File: doc/mem_seq_control.md
# mem_seq_control

Parametrised memory-stage access sequencer for the LC-3b pipeline. It sits beside the MEM stage and turns each memory opcode into an ordered chain of memory accesses. Direct accesses take one access. Indirect accesses take `INDIRECT_DEPTH` pointer fetches followed by one final access. The block stalls the pipeline with `proceed` until the chain completes. It drives the read/write strobes, the address-mux select and the captured pointer register.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `mem_rdata` and `ptr_reg`.
- `INDIRECT_DEPTH`, 1: number of pointer fetches for `op_ldi`/`op_sti`; legal range ≥ 1.
- `TIMEOUT_CYCLES`, 64: wait limit per access; used only with `MEM_SEQ_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `stage_valid`, input, 1: MEM stage holds a valid instruction.
- `opcode`, input, `lc3b_opcode`: opcode of the MEM-stage instruction.
- `mem_resp`, input, 1: memory completes the current access this cycle.
- `mem_rdata`, input, `DATA_WIDTH`: read data, valid when `mem_resp` is high.
- `proceed`, output, 1: pipeline may advance.
- `mem_read`, output, 1: read strobe.
- `mem_write`, output, 1: write strobe.
- `addr_sel`, output, 1: address source. 0 selects the computed effective address; 1 selects `ptr_reg`.
- `ptr_load`, output, 1: `ptr_reg` captures `mem_rdata` on this edge.
- `ptr_reg`, output, `DATA_WIDTH`: last captured pointer.
- `busy`, output, 1: a multi-access chain is in progress (state ≠ IDLE).
- `timeout_err`, output, 1: one-cycle abort pulse; tied 0 without the macro.

## Operation
Opcode classes:
- Direct load: `op_ldr`, `op_ldb`, `op_trap`.
- Direct store: `op_str`, `op_stb`.
- Indirect: `op_ldi` (final access is a read), `op_sti` (final access is a write).
- All other opcodes are non-memory.

States:
- **IDLE**, `addr_sel`=0:
  - `stage_valid` low, or a non-memory opcode: no strobes, `proceed`=1.
  - Direct opcode: assert `mem_read` or `mem_write` per class; `proceed`=`mem_resp`; remain in IDLE.
  - Indirect opcode: `mem_read`=1, `mem_write`=0, `proceed`=0. On `mem_resp`:
    - assert `ptr_load` and latch the store flag (opcode==`op_sti`);
    - `ptr_cnt`←1;
    - go to PTR if `INDIRECT_DEPTH`>1, else FINAL.
- **PTR**, `addr_sel`=1, `mem_read`=1, `mem_write`=0, `proceed`=0. On `mem_resp`:
  - assert `ptr_load`; `ptr_cnt`←`ptr_cnt`+1;
  - go to FINAL when the incremented count equals `INDIRECT_DEPTH`.
- **FINAL**, `addr_sel`=1:
  - `mem_write` = latched store flag; `mem_read` = its inverse.
  - `proceed`=`mem_resp`; on `mem_resp` go to IDLE.

Rules:
- `mem_write` is never asserted during a pointer fetch.
- After IDLE, `opcode` and `stage_valid` are ignored until the chain returns to IDLE.
- `ptr_cnt` width is $clog2(`INDIRECT_DEPTH`+1) and it never wraps.
- `ptr_reg` holds its value between chains.

## Timing
- Outputs are combinational from state, the latched flag and the current inputs. `ptr_reg` is registered.
- While `reset` is high: state=IDLE, `ptr_reg`=0, `ptr_cnt`=0, store flag=0, wait counter=0. Outputs are forced to `proceed`=0, `mem_read`=0, `mem_write`=0, `addr_sel`=0, `ptr_load`=0, `busy`=0, `timeout_err`=0.
- Reset mid-chain aborts immediately, with no completion pulse.
- Latency, counted from the first strobe with a 1-cycle-response memory:
  - direct access: 0 extra cycles (`proceed` high in the same cycle);
  - indirect access: `INDIRECT_DEPTH` stall cycles.
- Each access holds its strobe until `mem_resp`.
- A `mem_resp` arriving in the same cycle as a state entry completes that access.
- Back-to-back: an instruction in IDLE that completes its final access may be followed by a new instruction the next cycle with no bubble.

## Configuration
- `MEM_SEQ_TIMEOUT_EN` defined:
  - A wait counter, width $clog2(`TIMEOUT_CYCLES`+1), counts cycles that have a strobe but no `mem_resp`. It clears on `mem_resp` and on state change.
  - When it reaches `TIMEOUT_CYCLES`, that cycle sets `timeout_err`=1 and `proceed`=1 and drops the strobes, and the state returns to IDLE.
  - The instruction is discarded.
- Undefined: no counter is built; `timeout_err` is constant 0 and accesses wait indefinitely.

## Test plan
- `op_ldr`, `stage_valid`=1, `mem_resp` after 3 cycles → `mem_read`=1 for 3 cycles, `proceed`=0,0,1, `busy` stays 0.
- `op_ldi`, `INDIRECT_DEPTH`=1, `mem_rdata`=0x3000 on the first response → `ptr_load` pulse, `ptr_reg`=0x3000, FINAL with `addr_sel`=1 and `mem_read`=1, `proceed`=1 on the second response.
- `op_sti`, `INDIRECT_DEPTH`=3, immediate responses → 3 reads with `mem_write`=0, then 1 write; `busy` high for 3 cycles; `opcode` changed mid-chain still yields the write.
- `reset` asserted during PTR → all outputs 0 asynchronously, `ptr_reg`=0, next instruction begins from IDLE.
- With `MEM_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `op_stb` with no `mem_resp` → `timeout_err`=1 and `proceed`=1 on wait cycle 4, strobes low, IDLE next cycle.
- `op_add` and `stage_valid`=0 → `proceed`=1, no strobes.
